// File: rtl/tmds_channel_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tmds_channel_encoder (with tm_choice transition-minimisation stage)
// Description : Single-channel TMDS 8b/10b encoder with running-disparity DC
//               balancing and control tokens. Optional disparity monitor
//               enabled by defining TMDS_DISPARITY_MON_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module tm_choice (
   input  logic [7:0] data_in,
   output logic [8:0] q_m
);

   logic [3:0] w_ones;
   logic       w_use_xnor;
   logic [8:0] w_chain;

   always_comb begin
      w_ones = 4'd0;
      for (int i = 0; i < 8; i++) begin
         w_ones = w_ones + {3'd0, data_in[i]};
      end
      // XNOR chaining is chosen for dense words to minimise transitions.
      w_use_xnor = (w_ones > 4'd4) || ((w_ones == 4'd4) && !data_in[0]);
      w_chain    = 9'd0;
      w_chain[0] = data_in[0];
      for (int i = 1; i < 8; i++) begin
         w_chain[i] = w_use_xnor ? ~(w_chain[i-1] ^ data_in[i])
                                 :  (w_chain[i-1] ^ data_in[i]);
      end
      w_chain[8] = ~w_use_xnor;
   end

   assign q_m = w_chain;

endmodule

module tmds_channel_encoder #(
   parameter int CNT_WIDTH = 5
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic [7:0] data_in,
   input  logic [1:0] ctrl_in,
   input  logic       ve_in,
   output logic [9:0] tmds_out
`ifdef TMDS_DISPARITY_MON_EN
   ,
   output logic [CNT_WIDTH-1:0] disparity_out,
   output logic                 disparity_err
`endif
);

   localparam logic [9:0] c_TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] c_TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] c_TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] c_TOKEN_11 = 10'b1010101011;

   logic [8:0]                  w_q_m;
   logic [8:0]                  r_q_m;
   logic                        r_ve;
   logic [1:0]                  r_ctrl;
   logic [3:0]                  w_n1;
   logic                        w_case_a;
   logic                        w_case_b;
   logic signed [CNT_WIDTH-1:0] w_diff;
   logic signed [CNT_WIDTH-1:0] w_delta;
   logic signed [CNT_WIDTH-1:0] w_cnt_next;
   logic signed [CNT_WIDTH-1:0] r_cnt;
   logic [9:0]                  w_video_sym;
   logic [9:0]                  w_ctrl_sym;
   logic [9:0]                  r_tmds;

   tm_choice u_tm_choice (
      .data_in (data_in),
      .q_m     (w_q_m)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_q_m  <= 9'd0;
         r_ve   <= 1'b0;
         r_ctrl <= 2'b00;
      end else begin
         r_q_m  <= w_q_m;
         r_ve   <= ve_in;
         r_ctrl <= ctrl_in;
      end
   end

   always_comb begin
      w_n1 = 4'd0;
      for (int i = 0; i < 8; i++) begin
         w_n1 = w_n1 + {3'd0, r_q_m[i]};
      end
   end

   // N1 - N0 == 2*N1 - 8
   assign w_diff   = CNT_WIDTH'({w_n1, 1'b0}) - CNT_WIDTH'(8);
   assign w_case_a = (r_cnt == '0) || (w_n1 == 4'd4);
   assign w_case_b = (!r_cnt[CNT_WIDTH-1] && (w_n1 > 4'd4)) ||
                     ( r_cnt[CNT_WIDTH-1] && (w_n1 < 4'd4));

   always_comb begin
      w_video_sym = 10'd0;
      w_delta     = '0;
      if (w_case_a) begin
         w_video_sym = {~r_q_m[8], r_q_m[8], r_q_m[8] ? r_q_m[7:0] : ~r_q_m[7:0]};
         w_delta     = r_q_m[8] ? w_diff : -w_diff;
      end else if (w_case_b) begin
         w_video_sym = {1'b1, r_q_m[8], ~r_q_m[7:0]};
         w_delta     = (r_q_m[8] ? CNT_WIDTH'(2) : '0) - w_diff;
      end else begin
         w_video_sym = {1'b0, r_q_m[8], r_q_m[7:0]};
         w_delta     = w_diff - (r_q_m[8] ? '0 : CNT_WIDTH'(2));
      end
   end

   assign w_cnt_next = r_cnt + w_delta;

   always_comb begin
      w_ctrl_sym = c_TOKEN_00;
      case (r_ctrl)
         2'b00:   w_ctrl_sym = c_TOKEN_00;
         2'b01:   w_ctrl_sym = c_TOKEN_01;
         2'b10:   w_ctrl_sym = c_TOKEN_10;
         default: w_ctrl_sym = c_TOKEN_11;
      endcase
   end

   // Blanking forces disparity back to zero so each video run starts balanced.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_tmds <= 10'd0;
         r_cnt  <= '0;
      end else if (r_ve) begin
         r_tmds <= w_video_sym;
         r_cnt  <= w_cnt_next;
      end else begin
         r_tmds <= w_ctrl_sym;
         r_cnt  <= '0;
      end
   end

   assign tmds_out = r_tmds;

`ifdef TMDS_DISPARITY_MON_EN
   localparam logic signed [CNT_WIDTH:0] c_DISP_LIM = 10;

   logic signed [CNT_WIDTH:0] w_sum_wide;
   logic                      w_over;
   logic                      r_err;

   // One extra bit so an out-of-range sum is seen before it wraps.
   assign w_sum_wide = {r_cnt[CNT_WIDTH-1], r_cnt} + {w_delta[CNT_WIDTH-1], w_delta};
   assign w_over     = (w_sum_wide > c_DISP_LIM) || (w_sum_wide < -c_DISP_LIM);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_err <= 1'b0;
      end else if (r_ve && w_over) begin
         r_err <= 1'b1;
      end
   end

   assign disparity_out = r_cnt;
   assign disparity_err = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tmds_channel_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmds_channel_encoder
// Description : Scoreboard bench for tmds_channel_encoder against a behavioural
//               TMDS model; directed sequences plus randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_tmds_channel_encoder;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic [7:0] data_in;
   logic [1:0] ctrl_in;
   logic       ve_in;
   logic [9:0] tmds_out;
`ifdef TMDS_DISPARITY_MON_EN
   logic [4:0] disparity_out;
   logic       disparity_err;
`endif

   tmds_channel_encoder #(.CNT_WIDTH(5)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .data_in  (data_in),
      .ctrl_in  (ctrl_in),
      .ve_in    (ve_in),
      .tmds_out (tmds_out)
`ifdef TMDS_DISPARITY_MON_EN
      ,
      .disparity_out (disparity_out),
      .disparity_err (disparity_err)
`endif
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [9:0] sym;
      int         cnt;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   m_cnt = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check_val(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got 0x%0h (%0d) expected 0x%0h (%0d)",
                  name, cyc, act, act, exp, exp);
      end
   endtask

   // q_m[i] is the prefix parity of d[i:0]; the XNOR variant flips odd positions.
   function automatic logic [8:0] ref_qm(input logic [7:0] d);
      int         n1;
      bit         inv;
      logic [7:0] m;
      logic [8:0] q;
      n1  = $countones(d);
      inv = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      for (int i = 0; i < 8; i++) begin
         m    = 8'((1 << (i + 1)) - 1);
         q[i] = (^(d & m)) ^ (inv && (i % 2 == 1));
      end
      q[8] = !inv;
      return q;
   endfunction

   task automatic model_step(input bit ve, input logic [1:0] c, input logic [7:0] d,
                             output logic [9:0] sym);
      logic [8:0] qm;
      int         n1, n0, q8;
      if (!ve) begin
         m_cnt = 0;
         case (c)
            2'b00:   sym = 10'b1101010100;
            2'b01:   sym = 10'b0010101011;
            2'b10:   sym = 10'b0101010100;
            default: sym = 10'b1010101011;
         endcase
      end else begin
         qm = ref_qm(d);
         n1 = $countones(qm[7:0]);
         n0 = 8 - n1;
         q8 = int'(qm[8]);
         if (m_cnt == 0 || n1 == n0) begin
            sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            m_cnt = m_cnt + ((q8 == 1) ? (n1 - n0) : (n0 - n1));
         end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
            sym   = {1'b1, qm[8], ~qm[7:0]};
            m_cnt = m_cnt + 2 * q8 + (n0 - n1);
         end else begin
            sym   = {1'b0, qm[8], qm[7:0]};
            m_cnt = m_cnt + (n1 - n0) - 2 * (1 - q8);
         end
      end
   endtask

   task automatic drive(input bit ve, input logic [1:0] c, input logic [7:0] d);
      logic [9:0] sym;
      @(negedge clk_in);
      ve_in = ve; ctrl_in = c; data_in = d;
      model_step(ve, c, d, sym);
      sb.push_back('{sym, m_cnt, cyc + 2});
   endtask

   // Directed variant: the hand-derived symbol and cnt are what the DUT must show.
   task automatic drive_exp(input bit ve, input logic [1:0] c, input logic [7:0] d,
                            input logic [9:0] exp_sym, input int exp_cnt);
      logic [9:0] sym;
      @(negedge clk_in);
      ve_in = ve; ctrl_in = c; data_in = d;
      model_step(ve, c, d, sym);
      sb.push_back('{exp_sym, exp_cnt, cyc + 2});
   endtask

   task automatic release_reset();
      logic [9:0] sym;
      @(negedge clk_in);
      rst_n_in = 1'b1;
      ve_in = 1'b0; ctrl_in = 2'b00; data_in = 8'($urandom);
      m_cnt = 0;
      sb.push_back('{10'b1101010100, 0, cyc + 1});
      model_step(1'b0, 2'b00, data_in, sym);
      sb.push_back('{10'b1101010100, 0, cyc + 2});
   endtask

   task automatic async_reset_mid_cycle();
      @(posedge clk_in);
      #3;
      rst_n_in = 1'b0;
      sb.delete();
      m_cnt = 0;
      #1;
      check_val("async_reset_tmds", int'(tmds_out), 0);
`ifdef TMDS_DISPARITY_MON_EN
      check_val("async_reset_disp", int'(disparity_out), 0);
`endif
      repeat (2) begin
         @(negedge clk_in);
         ve_in = 1'b1; data_in = 8'($urandom); ctrl_in = 2'($urandom);
      end
   endtask

   always @(posedge clk_in) begin
      exp_t e;
      #1;
      if (rst_n_in && sb.size() > 0) begin
         if (sb[0].due < cyc) begin
            e = sb.pop_front();
            check_val("symbol_missed", cyc, e.due);
         end else if (sb[0].due == cyc) begin
            e = sb.pop_front();
            check_val("symbol", int'(tmds_out), int'(e.sym));
`ifdef TMDS_DISPARITY_MON_EN
            check_val("disparity", int'($signed(disparity_out)), e.cnt);
`endif
         end
      end
   end

   initial begin
      rst_n_in = 1'b0;
      ve_in    = 1'b1;
      ctrl_in  = 2'($urandom);
      data_in  = 8'($urandom);
      repeat (3) @(negedge clk_in);
      check_val("reset_tmds", int'(tmds_out), 0);
      release_reset();

      // Disparity walk from cnt=0 with data 0x00 (q_m = 0x100)
      drive_exp(1'b1, 2'b00, 8'h00, 10'b0100000000, -8);
      drive_exp(1'b1, 2'b00, 8'h00, 10'b1111111111, 2);
      drive_exp(1'b1, 2'b00, 8'h00, 10'b0100000000, -6);

      drive_exp(1'b0, 2'b00, 8'($urandom), 10'h354, 0);
      drive_exp(1'b0, 2'b01, 8'($urandom), 10'h0AB, 0);
      drive_exp(1'b0, 2'b10, 8'($urandom), 10'h154, 0);
      drive_exp(1'b0, 2'b11, 8'($urandom), 10'h2AB, 0);

      // One blanking cycle after cnt=+2 must give case A, not case C
      drive_exp(1'b1, 2'b00, 8'h00, 10'b0100000000, -8);
      drive_exp(1'b1, 2'b00, 8'h00, 10'b1111111111, 2);
      drive_exp(1'b0, 2'b00, 8'h5A, 10'h354, 0);
      drive_exp(1'b1, 2'b00, 8'h00, 10'b0100000000, -8);

      for (int i = 0; i < 256; i++) drive(1'b1, 2'b00, 8'(i));

      for (int i = 0; i < 64; i++) drive(i[0], 2'($urandom), 8'($urandom));

      for (int i = 0; i < 1500; i++)
         drive($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom));

      for (int i = 0; i < 20; i++) drive(1'b1, 2'b00, 8'($urandom));
      async_reset_mid_cycle();
      release_reset();
      drive_exp(1'b1, 2'b00, 8'h00, 10'b0100000000, -8);
      for (int i = 0; i < 40; i++) drive(1'b1, 2'($urandom), 8'($urandom));

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_in);
      check_val("scoreboard_drained", sb.size(), 0);
`ifdef TMDS_DISPARITY_MON_EN
      check_val("disparity_err_clear", int'(disparity_err), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
